// File: rtl/riscv_pkg.sv
// Shared RISC-V EX definitions: ALU ops, decode constants, FSM states.
// Used by ex_stage and mul_iter.
package riscv_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [6:0] FUN7_MUL = 7'b0000001;
  localparam int         MUL_STEPS = 64;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_BUSY,
    EX_DONE
  } ex_state_e;

  function automatic alu_op_e alu_decode(
    input logic [1:0] op,
    input logic [2:0] f3,
    input logic       f7b5
  );
    alu_op_e r;
    r = ALU_ADD;
    if (op == ALUOP_SUB) begin
      r = ALU_SUB;
    end else if (op[1]) begin
      unique case (f3)
        F3_ADD:  r = (op == ALUOP_R && f7b5) ? ALU_SUB : ALU_ADD;
        F3_SLL:  r = ALU_SLL;
        F3_SLT:  r = ALU_SLT;
        F3_SLTU: r = ALU_SLTU;
        F3_XOR:  r = ALU_XOR;
        F3_SR:   r = f7b5 ? ALU_SRA : ALU_SRL;
        F3_OR:   r = ALU_OR;
        default: r = ALU_AND;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [63:0] raw,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [63:0] mem_d,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [63:0] wb_d
  );
    logic [63:0] r;
    r = raw;
    if (mem_we && mem_rd == addr && addr != 5'd0) begin
      r = mem_d;
    end else if (wb_we && wb_rd == addr && addr != 5'd0) begin
      r = wb_d;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX payload, forwarding sources and EX results.
// master drives the instruction, slave is the EX stage.
interface ex_stage_if;
  logic        valid;
  logic        aluSrc;
  logic        branch;
  logic [1:0]  aluOp;
  logic [2:0]  fun3;
  logic [6:0]  fun7;
  logic [63:0] pc;
  logic [63:0] reg1;
  logic [63:0] reg2;
  logic [63:0] inme;
  logic [4:0]  addReadReg1;
  logic [4:0]  addReadReg2;
  logic [4:0]  memWrReg;
  logic        memRegWrite;
  logic [63:0] memData;
  logic [4:0]  wbWrReg;
  logic        wbRegWrite;
  logic [63:0] wbData;
  logic [63:0] aluResult;
  logic [63:0] storeData;
  logic [63:0] branchTarget;
  logic        branchTaken;
  logic        stall;
  logic        resultValid;

  modport master (
    output valid, aluSrc, branch, aluOp, fun3, fun7,
    output pc, reg1, reg2, inme,
    output addReadReg1, addReadReg2,
    output memWrReg, memRegWrite, memData,
    output wbWrReg, wbRegWrite, wbData,
    input  aluResult, storeData, branchTarget,
    input  branchTaken, stall, resultValid
  );

  modport slave (
    input  valid, aluSrc, branch, aluOp, fun3, fun7,
    input  pc, reg1, reg2, inme,
    input  addReadReg1, addReadReg2,
    input  memWrReg, memRegWrite, memData,
    input  wbWrReg, wbRegWrite, wbData,
    output aluResult, storeData, branchTarget,
    output branchTaken, stall, resultValid
  );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative 64x64 shift-add multiplier, one step per cycle.
// Only built when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module mul_iter
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        last;

  assign last    = (cnt_q == 6'(MUL_STEPS - 1));
  assign busy    = busy_q;
  assign done    = busy_q & last;
  assign product = acc_q;

  // load operands on start, then add-and-shift while busy
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // datapath registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// RV64 execute stage: forwarding, ALU, branch resolve.
// Optional iterative MUL under macro EX_MUL_EN.
module ex_stage
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex
);

  logic [63:0] op_a;
  logic [63:0] fwd_b;
  logic [63:0] op_b;
  logic [63:0] alu_res;
  logic [5:0]  shamt;
  logic        br_cond;
  alu_op_e     alu_op;

  assign op_a = fwd_sel(ex.addReadReg1, ex.reg1,
                        ex.memRegWrite, ex.memWrReg, ex.memData,
                        ex.wbRegWrite, ex.wbWrReg, ex.wbData);
  assign fwd_b = fwd_sel(ex.addReadReg2, ex.reg2,
                         ex.memRegWrite, ex.memWrReg, ex.memData,
                         ex.wbRegWrite, ex.wbWrReg, ex.wbData);
  assign op_b   = ex.aluSrc ? ex.inme : fwd_b;
  assign shamt  = op_b[5:0];
  assign alu_op = alu_decode(ex.aluOp, ex.fun3, ex.fun7[5]);

  assign ex.storeData    = fwd_b;
  assign ex.branchTarget = ex.pc + ex.inme;
  assign ex.branchTaken  = ex.valid & ex.branch & br_cond;

  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {63'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {63'd0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // branch condition on the two forwarded registers
  always_comb begin
    br_cond = 1'b0;
    unique case (ex.fun3)
      BR_EQ:   br_cond = (op_a == fwd_b);
      BR_NE:   br_cond = (op_a != fwd_b);
      BR_LT:   br_cond = ($signed(op_a) < $signed(fwd_b));
      BR_GE:   br_cond = ($signed(op_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (op_a < fwd_b);
      BR_GEU:  br_cond = (op_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_e   state_q, state_d;
  logic        is_mul;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_prod;
  logic        use_prod;
  logic        stall;
  logic        res_valid;
  logic        unused_mul;

  assign is_mul = (ex.aluOp == ALUOP_R) &&
                  (ex.fun7 == FUN7_MUL) &&
                  (ex.fun3 == F3_ADD);
  assign unused_mul = mul_busy;

  mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // MUL sequencing: accept in IDLE, 64 steps in BUSY, result in DONE
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    stall     = 1'b0;
    res_valid = ex.valid;
    use_prod  = 1'b0;
    unique case (state_q)
      EX_IDLE: begin
        if (ex.valid && is_mul) begin
          mul_start = 1'b1;
          stall     = 1'b1;
          res_valid = 1'b0;
          state_d   = EX_BUSY;
        end
      end
      EX_BUSY: begin
        stall     = 1'b1;
        res_valid = 1'b0;
        if (mul_done) begin
          state_d = EX_DONE;
        end
      end
      EX_DONE: begin
        res_valid = 1'b1;
        use_prod  = 1'b1;
        state_d   = EX_IDLE;
      end
      default: begin
        res_valid = 1'b0;
        state_d   = EX_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ex.aluResult   = use_prod ? mul_prod : alu_res;
  assign ex.stall       = stall;
  assign ex.resultValid = res_valid;
`else
  logic unused_ctl;

  assign unused_ctl = clk ^ rst ^ (^ex.fun7[6]) ^ (^ex.fun7[4:0]);

  assign ex.aluResult   = alu_res;
  assign ex.stall       = 1'b0;
  assign ex.resultValid = ex.valid;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage against a behavioural model.
// MUL sequences run when EX_MUL_EN is defined.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.valid = 0; bus.aluSrc = 0; bus.branch = 0;
    bus.aluOp = 0; bus.fun3 = 0; bus.fun7 = 0;
    bus.pc = 0; bus.reg1 = 0; bus.reg2 = 0; bus.inme = 0;
    bus.addReadReg1 = 0; bus.addReadReg2 = 0;
    bus.memWrReg = 0; bus.memRegWrite = 0; bus.memData = 0;
    bus.wbWrReg = 0; bus.wbRegWrite = 0; bus.wbData = 0;
  endtask

  function automatic logic [63:0] m_src(input logic [4:0] a,
                                        input logic [63:0] raw);
    if (a == 0) return raw;
    if (bus.memRegWrite && bus.memWrReg == a) return bus.memData;
    if (bus.wbRegWrite && bus.wbWrReg == a) return bus.wbData;
    return raw;
  endfunction

  function automatic logic [63:0] m_alu();
    logic [63:0] a, b;
    int sh;
    a = m_src(bus.addReadReg1, bus.reg1);
    b = bus.aluSrc ? bus.inme : m_src(bus.addReadReg2, bus.reg2);
    sh = int'(b % 64);
    if (bus.aluOp == 2'd0) return a + b;
    if (bus.aluOp == 2'd1) return a - b;
    case (bus.fun3)
      3'd0: return (bus.aluOp == 2'd2 && bus.fun7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: return (a < b) ? 64'd1 : 64'd0;
      3'd4: return a ^ b;
      3'd5: return bus.fun7[5] ? 64'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic m_br();
    logic [63:0] a, b;
    logic c;
    a = m_src(bus.addReadReg1, bus.reg1);
    b = m_src(bus.addReadReg2, bus.reg2);
    case (bus.fun3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) < $signed(b));
      3'd5: c = !($signed(a) < $signed(b));
      3'd6: c = (a < b);
      3'd7: c = !(a < b);
      default: c = 0;
    endcase
    return bus.valid & bus.branch & c;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int n;
    logic [63:0] v;
    clr();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_rvalid", 64'(bus.resultValid), 64'd0);
    chk("rst_brtaken", 64'(bus.branchTaken), 64'd0);

    // ADD with MEM forwarding on operand A
    @(negedge clk);
    clr();
    bus.valid = 1; bus.reg1 = 5; bus.addReadReg1 = 3;
    bus.memRegWrite = 1; bus.memWrReg = 3; bus.memData = 10;
    bus.reg2 = 7; bus.addReadReg2 = 6;
    #1;
    chk("add_fwd", bus.aluResult, 64'd17);
    chk("add_rvalid", 64'(bus.resultValid), 64'd1);
    chk("add_stall", 64'(bus.stall), 64'd0);

    // MEM beats WB on x4
    @(negedge clk);
    clr();
    bus.valid = 1; bus.reg1 = 100; bus.addReadReg1 = 4;
    bus.memRegWrite = 1; bus.memWrReg = 4; bus.memData = 1;
    bus.wbRegWrite = 1; bus.wbWrReg = 4; bus.wbData = 2;
    #1;
    chk("prio_mem", bus.aluResult, 64'd1);

    // WB only on operand B / storeData
    bus.memWrReg = 9; bus.addReadReg2 = 4; bus.reg2 = 55;
    #1;
    chk("wb_store", bus.storeData, 64'd2);

    // x0 never forwarded
    bus.addReadReg1 = 0; bus.addReadReg2 = 0;
    bus.memWrReg = 0; bus.wbWrReg = 0;
    #1;
    chk("x0_alu", bus.aluResult, 64'd155);
    chk("x0_store", bus.storeData, 64'd55);

    // BLT / BLTU with -1 and 1
    @(negedge clk);
    clr();
    bus.valid = 1; bus.branch = 1; bus.aluOp = 1;
    bus.fun3 = 3'b100; bus.reg1 = '1; bus.reg2 = 1;
    bus.addReadReg1 = 1; bus.addReadReg2 = 2;
    bus.pc = 64'h100; bus.inme = 64'h20;
    #1;
    chk("blt_taken", 64'(bus.branchTaken), 64'd1);
    chk("blt_target", bus.branchTarget, 64'h120);
    bus.fun3 = 3'b110;
    #1;
    chk("bltu_taken", 64'(bus.branchTaken), 64'd0);
    bus.fun3 = 3'b010;
    #1;
    chk("br_badf3", 64'(bus.branchTaken), 64'd0);

    // wrap-around of the branch target
    bus.pc = '1; bus.inme = 64'd2;
    #1;
    chk("target_wrap", bus.branchTarget, 64'd1);

`ifdef EX_MUL_EN
    // all-ones times 3
    @(negedge clk);
    clr();
    bus.valid = 1; bus.aluOp = 2; bus.fun7 = 7'b0000001;
    bus.reg1 = '1; bus.reg2 = 3;
    bus.addReadReg1 = 1; bus.addReadReg2 = 2;
    #1;
    chk("mul_acc_rvalid", 64'(bus.resultValid), 64'd0);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      bus.valid = 0;
      bus.reg1 = r64();
      bus.reg2 = r64();
      #1;
    end
    chk("mul_stall_len", 64'(n), 64'd65);
    chk("mul_result", bus.aluResult, 64'hFFFFFFFFFFFFFFFD);
    chk("mul_rvalid", 64'(bus.resultValid), 64'd1);
    @(negedge clk);
    #1;
    chk("mul_after_rv", 64'(bus.resultValid), 64'd0);
    chk("mul_after_st", 64'(bus.stall), 64'd0);

    // reset in BUSY cycle 30 aborts
    @(negedge clk);
    clr();
    bus.valid = 1; bus.aluOp = 2; bus.fun7 = 7'b0000001;
    bus.reg1 = 6; bus.reg2 = 7;
    repeat (30) begin
      @(negedge clk);
      bus.valid = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_stall", 64'(bus.stall), 64'd0);
    chk("abort_rvalid", 64'(bus.resultValid), 64'd0);

    // 6x7 with MUL held valid: no restart in DONE
    @(negedge clk);
    bus.valid = 1;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mul2_stall_len", 64'(n), 64'd65);
    chk("mul2_result", bus.aluResult, 64'd42);
    chk("mul2_rvalid", 64'(bus.resultValid), 64'd1);
    @(negedge clk);
    #1;
    chk("mul2_restart", 64'(bus.stall), 64'd1);
    chk("mul2_re_rv", 64'(bus.resultValid), 64'd0);
    @(negedge clk);
    clr();
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mul2_rst", 64'(bus.stall), 64'd0);
`else
    // MUL encoding executes as ADD
    @(negedge clk);
    clr();
    bus.valid = 1; bus.aluOp = 2; bus.fun7 = 7'b0000001;
    bus.reg1 = 6; bus.reg2 = 7;
    bus.addReadReg1 = 1; bus.addReadReg2 = 2;
    #1;
    chk("mul_as_add", bus.aluResult, 64'd13);
    n = 0;
    repeat (70) begin
      @(negedge clk);
      #1;
      if (bus.stall !== 1'b0) n++;
    end
    chk("no_stall", 64'(n), 64'd0);
`endif

    // randomized single-cycle traffic
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.valid = 1'($urandom);
      bus.aluSrc = 1'($urandom);
      bus.branch = 1'($urandom);
      bus.aluOp = 2'($urandom);
      bus.fun3 = 3'($urandom);
      case ($urandom_range(3))
        0: bus.fun7 = 7'h00;
        1: bus.fun7 = 7'h20;
        2: bus.fun7 = 7'h01;
        default: bus.fun7 = 7'($urandom);
      endcase
`ifdef EX_MUL_EN
      if (bus.aluOp == 2 && bus.fun3 == 0 && bus.fun7 == 7'h01)
        bus.fun7 = 7'h00;
`endif
      bus.pc = r64();
      bus.inme = ($urandom_range(1) == 0) ? 64'($urandom_range(70)) : r64();
      v = r64();
      bus.reg1 = ($urandom_range(3) == 0) ? bus.reg2 : r64();
      bus.reg2 = ($urandom_range(3) == 0) ? v : 64'($urandom_range(70));
      bus.addReadReg1 = 5'($urandom_range(3));
      bus.addReadReg2 = 5'($urandom_range(3));
      bus.memWrReg = 5'($urandom_range(3));
      bus.memRegWrite = 1'($urandom);
      bus.memData = r64();
      bus.wbWrReg = 5'($urandom_range(3));
      bus.wbRegWrite = 1'($urandom);
      bus.wbData = r64();
      #1;
      chk("rnd_alu", bus.aluResult, m_alu());
      chk("rnd_store", bus.storeData,
          m_src(bus.addReadReg2, bus.reg2));
      chk("rnd_target", bus.branchTarget, bus.pc + bus.inme);
      chk("rnd_taken", 64'(bus.branchTaken), 64'(m_br()));
      chk("rnd_rvalid", 64'(bus.resultValid), 64'(bus.valid));
      chk("rnd_stall", 64'(bus.stall), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
